reg_access_ctrl: RTL
====================

# reg_access_ctrl

Multi-cycle instruction sequencer that drives the 8×8-bit register file: it issues the read addresses, captures the two read operands, computes the result or performs a data-memory access, then drives the write port. It sits between the instruction source and the register file/data memory. It issues exactly one register-file write per writing instruction and handles memory stalls through a busywait handshake.

## Interface
- No parameters. Data width is fixed at 8 bits, register address width at 3 bits.
- CLK  input  1  system clock; all state changes on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- INSTRUCTION  input  32  fields: [31:24] OP, [23:16] RD, [15:8] RT, [7:0] RS/IMM. Register fields use bits [2:0] only.
- INSTR_VALID  input  1  instruction available.
- INSTR_READY  output  1  controller can accept an instruction.
- OUT1ADDRESS, OUT2ADDRESS  output  3 each  register-file read addresses.
- REGOUT1, REGOUT2  input  8 each  register-file read data.
- INADDRESS  output  3  register-file write address.
- REGIN  output  8  register-file write data.
- WRITE  output  1  register-file write enable.
- MEM_READ, MEM_WRITE  output  1 each  data-memory request.
- MEM_ADDRESS  output  8  memory address.
- MEM_WRITEDATA  output  8  memory write data.
- MEM_READDATA  input  8  memory read data.
- MEM_BUSYWAIT  input  1  memory stall.
- ERROR  output  1  one-cycle pulse when an illegal opcode is seen.

## Operation
- Opcodes:
  - 0x00 loadi: RD ← IMM.
  - 0x01 mov: RD ← R[RS].
  - 0x02 add: RD ← R[RT] + R[RS].
  - 0x03 sub: RD ← R[RT] − R[RS].
  - 0x04 and: RD ← R[RT] & R[RS].
  - 0x05 or: RD ← R[RT] | R[RS].
  - 0x08 lwd: RD ← MEM[R[RS]].
  - 0x0A swd: MEM[R[RS]] ← R[RT].
  - Any other opcode is illegal.
- Arithmetic is 8-bit modulo 2^8. Carry and borrow are discarded (0xFF+0x01=0x00; 0x00−0x01=0xFF).
- States are IDLE, READ, EXEC, MEM, WB.
  - IDLE: INSTR_READY=1. On a rising edge with INSTR_VALID=1, latch INSTRUCTION and go to READ. Otherwise stay in IDLE.
  - READ: drive OUT1ADDRESS=RT[2:0] and OUT2ADDRESS=RS[2:0]. Always go to EXEC.
  - EXEC: capture REGOUT1/REGOUT2 and decode.
    - Illegal opcode: pulse ERROR, go to IDLE, no write.
    - loadi, mov, ALU ops: register the result and go to WB.
    - lwd/swd: register MEM_ADDRESS=REGOUT2. For swd also register MEM_WRITEDATA=REGOUT1. Go to MEM.
  - MEM: assert MEM_READ (lwd) or MEM_WRITE (swd). Minimum stay is one cycle. Leave on the first edge where MEM_BUSYWAIT=0.
    - lwd: capture MEM_READDATA and go to WB.
    - swd: go to IDLE.
    - MEM_READ/MEM_WRITE deassert as the state leaves MEM.
  - WB: WRITE=1, INADDRESS=RD[2:0], REGIN=result for exactly one cycle. Go to IDLE. The register file samples on the edge that ends WB.
- Read addresses are registered outputs. They hold their last value outside READ so that register-file outputs stay stable.
- Reset (asynchronous): state goes to IDLE immediately. WRITE, MEM_READ, MEM_WRITE and ERROR go to 0. Address, data and latched-instruction registers go to 0.
  - INSTR_READY = (state==IDLE) & ~RESET, so it is 0 while RESET is high.
  - Reset during any state aborts the instruction: no write, no memory request after reset asserts.
- An instruction offered while not in IDLE is ignored. The source must hold INSTR_VALID until INSTR_READY is seen high at an edge.

## Timing
- Accept edge = E0.
- loadi/mov/ALU/illegal: READ in cycle E0–E1, EXEC in E1–E2.
  - Writing ops: WB in E2–E3, register written at E3. INSTR_READY high again after E3.
  - Illegal: ERROR high in E2–E3, then IDLE.
  - Throughput is one instruction per 4 cycles (accept→accept) with back-to-back VALID.
- lwd/swd: MEM entered at E2.
  - With MEM_BUSYWAIT low at E3: lwd writes at E4, swd returns to IDLE at E3.
  - Each cycle of MEM_BUSYWAIT high adds one cycle.
- The register-file read path has combinational delay (<1 clock period). Operands are sampled one full cycle after the addresses change, never in the same cycle.
- REGIN and INADDRESS are stable for the whole WB cycle, including the register file's post-edge sampling window.

## Test plan
- Reset then loadi R2,0x5A → WRITE=1 with INADDRESS=2, REGIN=0x5A in cycle E2–E3 only. INSTR_READY=0 from E0 to E3.
- Preload R1=0xFF, R3=0x01; add R4,R1,R3 → REGIN=0x00. sub R5,R3,R1 → REGIN=0x02. and → 0x01. or → 0xFF.
- lwd R6,R1 with MEM_BUSYWAIT high for 3 cycles and MEM_READDATA=0xC3:
  - MEM_READ=1, MEM_ADDRESS=0xFF for 4 cycles.
  - R6 written with 0xC3 one cycle later.
  - No WRITE pulse during the stall.
- swd R2,R3 → MEM_WRITE=1, MEM_ADDRESS=0x01, MEM_WRITEDATA=0x5A. WRITE stays 0 throughout.
- Opcode 0x07 → ERROR high for exactly one cycle, no WRITE, INSTR_READY high the following cycle.
- Assert RESET mid-WB and mid-MEM (between edges) → WRITE and MEM_* drop to 0 immediately, register contents unchanged, state IDLE after release.

Source files
------------

// File: rtl/reg_access_ctrl.sv
// rtl/reg_access_ctrl.sv - multi-cycle sequencer driving an 8x8-bit register file and a data memory
//
// Purpose:
//   Accepts one 32-bit instruction at a time ({OP, RD, RT, RS/IMM}). Issues the
//   register-file read addresses, captures the two operands one full cycle later,
//   then either computes a result or performs a data-memory access. It finishes
//   with exactly one register-file write for writing instructions.
//   States: IDLE -> READ -> EXEC -> (MEM) -> (WB) -> IDLE.
//
// Ports:
//   CLK, RESET                 clock, asynchronous active-high reset
//   INSTRUCTION, INSTR_VALID   instruction input and its valid flag
//   INSTR_READY                high in IDLE (and not in reset): instruction can be accepted
//   OUT1ADDRESS, OUT2ADDRESS   registered read addresses (RT, RS)
//   REGOUT1, REGOUT2           register-file read data for OUT1ADDRESS / OUT2ADDRESS
//   INADDRESS, REGIN, WRITE    register-file write port
//   MEM_READ, MEM_WRITE        data-memory request strobes
//   MEM_ADDRESS, MEM_WRITEDATA data-memory address and store data
//   MEM_READDATA, MEM_BUSYWAIT data-memory load data and stall
//   ERROR                      one-cycle pulse on an illegal opcode
module reg_access_ctrl (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION,
    input  logic        INSTR_VALID,
    output logic        INSTR_READY,
    output logic [2:0]  OUT1ADDRESS,
    output logic [2:0]  OUT2ADDRESS,
    input  logic [7:0]  REGOUT1,
    input  logic [7:0]  REGOUT2,
    output logic [2:0]  INADDRESS,
    output logic [7:0]  REGIN,
    output logic        WRITE,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [7:0]  MEM_ADDRESS,
    output logic [7:0]  MEM_WRITEDATA,
    input  logic [7:0]  MEM_READDATA,
    input  logic        MEM_BUSYWAIT,
    output logic        ERROR
);

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_LWD   = 8'h08;
    localparam logic [7:0] OP_SWD   = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_EXEC = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] op_q, op_d;
    logic [2:0] rd_q, rd_d;
    logic [7:0] imm_q, imm_d;
    logic [2:0] out1_addr_q, out1_addr_d;
    logic [2:0] out2_addr_q, out2_addr_d;
    logic [7:0] result_q, result_d;
    logic [7:0] mem_addr_q, mem_addr_d;
    logic [7:0] mem_wdata_q, mem_wdata_d;
    logic       write_q, write_d;
    logic       mem_read_q, mem_read_d;
    logic       mem_write_q, mem_write_d;
    logic       error_q, error_d;

    // Only bits [2:0] of the RD and RT fields address a register.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{INSTRUCTION[23:19], INSTRUCTION[15:11]};

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rd_d        = rd_q;
        imm_d       = imm_q;
        out1_addr_d = out1_addr_q;
        out2_addr_d = out2_addr_q;
        result_d    = result_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        write_d     = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        error_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (INSTR_VALID) begin
                    op_d        = INSTRUCTION[31:24];
                    rd_d        = INSTRUCTION[18:16];
                    imm_d       = INSTRUCTION[7:0];
                    // Addresses are loaded on the accept edge so they are stable
                    // for the whole READ cycle; operands are sampled at the end of EXEC.
                    out1_addr_d = INSTRUCTION[10:8];
                    out2_addr_d = INSTRUCTION[2:0];
                    state_d     = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (op_q)
                    OP_LOADI: begin result_d = imm_q;             state_d = ST_WB; write_d = 1'b1; end
                    OP_MOV:   begin result_d = REGOUT2;           state_d = ST_WB; write_d = 1'b1; end
                    OP_ADD:   begin result_d = REGOUT1 + REGOUT2; state_d = ST_WB; write_d = 1'b1; end
                    OP_SUB:   begin result_d = REGOUT1 - REGOUT2; state_d = ST_WB; write_d = 1'b1; end
                    OP_AND:   begin result_d = REGOUT1 & REGOUT2; state_d = ST_WB; write_d = 1'b1; end
                    OP_OR:    begin result_d = REGOUT1 | REGOUT2; state_d = ST_WB; write_d = 1'b1; end
                    OP_LWD: begin
                        mem_addr_d = REGOUT2;
                        mem_read_d = 1'b1;
                        state_d    = ST_MEM;
                    end
                    OP_SWD: begin
                        mem_addr_d  = REGOUT2;
                        mem_wdata_d = REGOUT1;
                        mem_write_d = 1'b1;
                        state_d     = ST_MEM;
                    end
                    default: begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                endcase
            end
            ST_MEM: begin
                if (MEM_BUSYWAIT) begin
                    // Hold the request until the memory stops stalling.
                    mem_read_d  = mem_read_q;
                    mem_write_d = mem_write_q;
                end else if (mem_read_q) begin
                    result_d = MEM_READDATA;
                    write_d  = 1'b1;
                    state_d  = ST_WB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            op_q        <= 8'h00;
            rd_q        <= 3'd0;
            imm_q       <= 8'h00;
            out1_addr_q <= 3'd0;
            out2_addr_q <= 3'd0;
            result_q    <= 8'h00;
            mem_addr_q  <= 8'h00;
            mem_wdata_q <= 8'h00;
            write_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            out1_addr_q <= out1_addr_d;
            out2_addr_q <= out2_addr_d;
            result_q    <= result_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            write_q     <= write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            error_q     <= error_d;
        end
    end

    assign INSTR_READY   = (state_q == ST_IDLE) & ~RESET;
    assign OUT1ADDRESS   = out1_addr_q;
    assign OUT2ADDRESS   = out2_addr_q;
    assign INADDRESS     = rd_q;
    assign REGIN         = result_q;
    assign WRITE         = write_q;
    assign MEM_READ      = mem_read_q;
    assign MEM_WRITE     = mem_write_q;
    assign MEM_ADDRESS   = mem_addr_q;
    assign MEM_WRITEDATA = mem_wdata_q;
    assign ERROR         = error_q;

endmodule
